// File: rtl/ma_filter_sequencer_if.sv
// Sequencer <-> ROM / filter / host signal bundle.
// master: the sequencer side; slave: the environment (ROM, filter, host).
// Control inputs (start/stop/div) and status outputs travel with the datapath.
interface ma_filter_sequencer_if #(
  parameter int N     = 16,
  parameter int AW    = 7,
  parameter int DIV_W = 8
);
  logic             start;
  logic             stop;
  logic [DIV_W-1:0] div;
  logic [AW-1:0]    mem_addr;
  logic [N-1:0]     mem_data;
  logic             filt_clr;
  logic             filt_en;
  logic [N-1:0]     filt_din;
  logic [N-1:0]     filt_dout;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    input  start, stop, div, mem_data, filt_dout,
    output mem_addr, filt_clr, filt_en, filt_din, out_data, out_valid,
           busy, done, wrap
  );

  modport slave (
    output start, stop, div, mem_data, filt_dout,
    input  mem_addr, filt_clr, filt_en, filt_din, out_data, out_valid,
           busy, done, wrap
  );
endinterface

// File: rtl/ma_filter_sequencer.sv
// Moving-average filter sequencer: ROM read, TAPS-cycle flush, paced sample feed, result capture.
// Latency: sample strobe 1 clk after each pacing tick; result captured 1 clk after filt_dout is valid.
// Backpressure: none; pacing is set by div, stop aborts into DRAIN. Build option MA_SEQ_LOOP_EN = endless wrap.
module ma_filter_sequencer #(
  parameter int N     = 16,
  parameter int DEPTH = 95,
  parameter int AW    = 7,
  parameter int TAPS  = 4,
  parameter int DIV_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  ma_filter_sequencer_if.master bus
);

  localparam int              FW         = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [FW-1:0]   LAST_FLUSH = FW'(TAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [AW-1:0]    mem_addr_q,  mem_addr_d;
  logic             filt_clr_q,  filt_clr_d;
  logic             filt_en_q,   filt_en_d;
  logic [N-1:0]     filt_din_q,  filt_din_d;
  logic             cap_q,       cap_d;
  logic [N-1:0]     out_data_q,  out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             wrap_q,      wrap_d;
  logic [DIV_W-1:0] pc_q,        pc_d;
  logic [DIV_W-1:0] per_q,       per_d;
  logic [FW-1:0]    fl_cnt_q,    fl_cnt_d;
  logic             arm_q,       arm_d;

  logic             tick;
  logic [DIV_W-1:0] per_eff;

  // A divider of 0 would leave no cycle for the ROM read; treat it as 1.
  assign per_eff = (bus.div == '0) ? DIV_W'(1) : bus.div;
  assign tick    = (pc_q == per_q);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    filt_clr_d  = filt_clr_q;
    filt_en_d   = 1'b0;
    filt_din_d  = filt_din_q;
    // Only RUN strobes (not flush strobes) produce a result to capture.
    cap_d       = filt_en_q & ~filt_clr_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    pc_d        = pc_q;
    per_d       = per_q;
    fl_cnt_d    = fl_cnt_q;
    // start must be seen low before it can launch another pass, so a held
    // start yields exactly one pass.
    arm_d       = ~bus.start;

    // Capture runs independently of state so an in-flight sample survives stop.
    if (cap_q) begin
      out_data_d  = bus.filt_dout;
      out_valid_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // The cycle carrying done ignores start.
        if (bus.start && arm_q && !done_q) begin
          state_d    = S_FLUSH;
          mem_addr_d = '0;
          fl_cnt_d   = '0;
          filt_clr_d = 1'b1;
          filt_en_d  = 1'b1;
          filt_din_d = '0;
          busy_d     = 1'b1;
        end
      end

      S_FLUSH: begin
        if (bus.stop) begin
          state_d    = S_DRAIN;
          filt_clr_d = 1'b0;
        end else if (fl_cnt_q == LAST_FLUSH) begin
          state_d    = S_RUN;
          filt_clr_d = 1'b0;
          pc_d       = '0;
          per_d      = per_eff;
        end else begin
          fl_cnt_d   = fl_cnt_q + 1'b1;
          filt_clr_d = 1'b1;
          filt_en_d  = 1'b1;
          filt_din_d = '0;
        end
      end

      S_RUN: begin
        if (tick) begin
          // mem_data already reflects mem_addr: it has been stable >= 1 clk.
          pc_d       = '0;
          per_d      = per_eff;
          filt_din_d = bus.mem_data;
          filt_en_d  = 1'b1;
          if (mem_addr_q == LAST_ADDR) begin
`ifdef MA_SEQ_LOOP_EN
            mem_addr_d = '0;
            wrap_d     = 1'b1;
`else
            state_d    = S_DRAIN;
`endif
          end else begin
            mem_addr_d = mem_addr_q + 1'b1;
          end
        end else begin
          pc_d = pc_q + 1'b1;
        end
        // A stop coinciding with a tick still lets that tick's strobe out.
        if (bus.stop) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Hold while the last strobe is on the wire; its capture then lands
        // together with done.
        if (!filt_en_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_addr_q  <= '0;
      filt_clr_q  <= 1'b0;
      filt_en_q   <= 1'b0;
      filt_din_q  <= '0;
      cap_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      pc_q        <= '0;
      per_q       <= DIV_W'(1);
      fl_cnt_q    <= '0;
      arm_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      filt_clr_q  <= filt_clr_d;
      filt_en_q   <= filt_en_d;
      filt_din_q  <= filt_din_d;
      cap_q       <= cap_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      pc_q        <= pc_d;
      per_q       <= per_d;
      fl_cnt_q    <= fl_cnt_d;
      arm_q       <= arm_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.filt_clr  = filt_clr_q;
  assign bus.filt_en   = filt_en_q;
  assign bus.filt_din  = filt_din_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap      = wrap_q;

endmodule
